gu_mod_counter: RTL and testbench

Parametrised successor to the general-use counter for the accelerometer driver. Adds a programmable terminal count, three run modes (wrap, saturate, one-shot), synchronous parallel load, a one-cycle terminal-count pulse and a sticky overflow flag. Used for SPI bit/byte sequencing, sample-interval timing and timeout supervision, where a bare free-running count is not enough.

---
 rtl/gu_mod_counter.sv | 136 +++++++++++++
 tb/tb_gu_mod_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gu_mod_counter.sv
// Programmable terminal-count counter with WRAP / SATURATE / ONESHOT modes, parallel load,
// tc pulse and sticky overflow. Optional tick prescaler: define GU_MOD_COUNTER_PRESCALER_EN.
module gu_mod_counter #(
  parameter int BITS          = 10,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [BITS-1:0]          limit,
  input  logic                     start,
  input  logic                     load,
  input  logic [BITS-1:0]          load_value,
  input  logic [PRESCALE_BITS-1:0] prescale_div,
  output logic [BITS-1:0]          count,
  output logic                     tc,
  output logic                     overflow,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {M_WRAP = 2'd0, M_SAT = 2'd1, M_ONESHOT = 2'd2, M_RSVD = 2'd3} mode_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] count_q, count_d, count_plus;
  logic            tc_q, tc_d, ovf_q, ovf_d;
  logic            tick, at_term, is_oneshot, start_eff, presc_clr;
  mode_e           mode_s;

  assign mode_s     = mode_e'(mode);
  assign is_oneshot = (mode_s == M_ONESHOT);
  assign start_eff  = start && is_oneshot;
  assign at_term    = (count_q >= limit);
  // Only evaluated when count < limit, so it can never roll over.
  assign count_plus = count_q + BITS'(1);

`ifdef GU_MOD_COUNTER_PRESCALER_EN
  logic [PRESCALE_BITS-1:0] presc_q, presc_d;

  assign tick = enable && (presc_q == prescale_div);

  always_comb begin
    presc_d = presc_q;
    if (presc_clr)   presc_d = '0;
    else if (enable) presc_d = tick ? '0 : presc_q + PRESCALE_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end
`else
  logic unused_presc;
  assign unused_presc = ^prescale_div;
  assign tick         = enable;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    count_d   = count_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    state_d   = state_q;
    presc_clr = 1'b0;

    if (clear) begin
      count_d   = '0;
      ovf_d     = 1'b0;
      state_d   = IDLE;
      presc_clr = 1'b1;
    end else if (load) begin
      count_d   = load_value;
      presc_clr = 1'b1;
    end else if (start_eff) begin
      count_d   = '0;
      state_d   = RUN;
      presc_clr = 1'b1;
    end else if (tick) begin
      case (mode_s)
        M_SAT: begin
          if (!at_term) begin
            count_d = count_plus;
            tc_d    = (count_plus == limit);
          end
        end
        M_ONESHOT: begin
          if (state_q == RUN) begin
            if (!at_term) begin
              count_d = count_plus;
            end else begin
              tc_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
        default: begin
          if (at_term) begin
            count_d = '0;
            tc_d    = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            count_d = count_plus;
          end
        end
      endcase
    end

    // The FSM only lives in ONESHOT; any other mode parks it in IDLE.
    if (!is_oneshot) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_gu_mod_counter.sv
// Self-checking bench for gu_mod_counter: directed test-plan scenarios plus random stimulus,
// all checked against a behavioural model of the counter rules.
module tb_gu_mod_counter;

  localparam int BITS  = 4;
  localparam int PBITS = 4;

  logic             clk = 1'b0;
  logic             reset, clear, enable, start, load;
  logic [1:0]       mode;
  logic [BITS-1:0]  limit, load_value;
  logic [PBITS-1:0] prescale_div;
  logic [BITS-1:0]  count;
  logic             tc, overflow, busy, done;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model: plain integers, FSM held as two flags.
  int m_count, m_pre;
  bit m_tc, m_ovf, m_busy, m_done;

  gu_mod_counter #(.BITS(BITS), .PRESCALE_BITS(PBITS)) dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .limit(limit), .start(start), .load(load), .load_value(load_value),
    .prescale_div(prescale_div), .count(count), .tc(tc), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply the counter rules to the inputs currently driven, producing post-edge values.
  task automatic model_step();
    bit tk;
    bit one = (mode == 2'd2);
`ifdef GU_MOD_COUNTER_PRESCALER_EN
    tk = enable && (m_pre == int'(prescale_div));
`else
    tk = enable;
`endif
    m_tc = 1'b0;
    if (reset) begin
      m_count = 0; m_ovf = 0; m_busy = 0; m_done = 0; m_pre = 0;
    end else if (clear) begin
      m_count = 0; m_ovf = 0; m_busy = 0; m_done = 0; m_pre = 0;
    end else if (load) begin
      m_count = int'(load_value); m_pre = 0;
    end else if (start && one) begin
      m_count = 0; m_busy = 1; m_done = 0; m_pre = 0;
    end else begin
      if (enable) m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        if (mode == 2'd1) begin
          if (m_count < int'(limit)) begin
            m_count++;
            m_tc = (m_count == int'(limit));
          end
        end else if (one) begin
          if (m_busy) begin
            if (m_count < int'(limit)) m_count++;
            else begin m_tc = 1; m_busy = 0; m_done = 1; end
          end
        end else begin
          if (m_count >= int'(limit)) begin m_count = 0; m_tc = 1; m_ovf = 1; end
          else m_count++;
        end
      end
    end
    if (!one) begin m_busy = 0; m_done = 0; end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("count",    int'(count),    m_count);
    check("tc",       int'(tc),       int'(m_tc));
    check("overflow", int'(overflow), int'(m_ovf));
    check("busy",     int'(busy),     int'(m_busy));
    check("done",     int'(done),     int'(m_done));
  endtask

  task automatic idle_inputs();
    reset = 0; clear = 0; enable = 0; start = 0; load = 0;
  endtask

  initial begin
    m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0; m_busy = 0; m_done = 0;
    idle_inputs();
    mode = 2'd0; limit = '0; load_value = '0; prescale_div = '0;

    // Reset state
    reset = 1; cycle(); cycle();
    reset = 0;
    check("rst_count", int'(count), 0);
    check("rst_flags", int'({tc, overflow, busy, done}), 0);

    // WRAP, limit=5: 1..5 then 0 with tc, overflow sticky
    mode = 2'd0; limit = 4'd5; enable = 1;
    for (int i = 0; i < 6; i++) cycle();
    check("wrap_term_count", int'(count), 0);
    check("wrap_term_tc", int'(tc), 1);
    cycle();
    check("wrap_tc_single", int'(tc), 0);
    check("wrap_ovf_sticky", int'(overflow), 1);

    // SATURATE, limit=3: 1,2,3,3,3,3 with one tc
    enable = 0; clear = 1; cycle(); clear = 0;
    check("clear_ovf", int'(overflow), 0);
    mode = 2'd1; limit = 4'd3; enable = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 2) check("sat_first_tc", int'(tc), 1);
    end
    check("sat_hold", int'(count), 3);
    check("sat_no_ovf", int'(overflow), 0);

    // ONESHOT, limit=2
    enable = 0; mode = 2'd2; limit = 4'd2; start = 1; cycle(); start = 0;
    check("os_busy", int'(busy), 1);
    enable = 1;
    for (int i = 0; i < 3; i++) cycle();
    check("os_done", int'(done), 1);
    check("os_tc", int'(tc), 1);
    check("os_cnt", int'(count), 2);
    cycle();
    check("os_hold", int'(count), 2);
    start = 1; cycle(); start = 0;
    check("os_restart", int'({busy, count}), 16);

    // Priority: clear beats load beats tick; reset in RUN clears everything
    mode = 2'd0; limit = 4'd15; load_value = 4'd9;
    load = 1; clear = 1; enable = 1; cycle(); clear = 0;
    check("prio_clear", int'(count), 0);
    cycle(); load = 0;
    check("prio_load", int'(count), 9);
    mode = 2'd2; enable = 0; start = 1; cycle(); start = 0;
    enable = 1; cycle();
    reset = 1; cycle(); reset = 0;
    check("rst_run", int'({count, tc, overflow, busy, done}), 0);

    // Lowering limit below count terminates on the next tick
    mode = 2'd0; limit = 4'd10; load_value = 4'd7; load = 1; enable = 0; cycle(); load = 0;
    limit = 4'd4; enable = 1; cycle();
    check("lim_drop", int'({count, tc}), 1);

    // limit=0 corner in all three modes
    limit = 4'd0; cycle(); cycle();
    mode = 2'd1; cycle(); cycle();
    mode = 2'd2; start = 1; cycle(); start = 0; cycle();

`ifdef GU_MOD_COUNTER_PRESCALER_EN
    // Prescaled WRAP with an enable gap
    idle_inputs(); clear = 1; cycle(); clear = 0;
    mode = 2'd0; limit = 4'd15; prescale_div = 4'd2; enable = 1;
    for (int i = 0; i < 7; i++) cycle();
    enable = 0;
    for (int i = 0; i < 5; i++) cycle();
    enable = 1;
    for (int i = 0; i < 6; i++) cycle();
`endif

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      clear      = ($urandom_range(0, 49) == 0);
      load       = ($urandom_range(0, 19) == 0);
      start      = ($urandom_range(0, 9) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      load_value = BITS'($urandom);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 24) == 0) limit = ($urandom_range(0, 5) == 0) ? '0 : BITS'($urandom);
      if ($urandom_range(0, 49) == 0) prescale_div = PBITS'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
